pwm_duty_sequencer: RTL

Slew-limited duty controller that sits between the board switches and `PWM_Generator`. It synchronises the 4-bit switch code into a target duty. It ramps its 4-bit `duty` output toward that target one code per step interval, and that output drives the generator's `SW` input. The result is soft-start and soft-stop on the PWM output instead of abrupt duty jumps.

---
 rtl/pwm_duty_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/pwm_duty_sequencer.sv
// Slew-limited duty ramp feeding PWM_Generator.SW, one code per step tick.
// Optional switch debounce is built when PWM_SEQ_DEBOUNCE_EN is defined.
module pwm_duty_sequencer #(
  parameter int STEP_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic       enable,
  output logic [3:0] duty,
  output logic       busy,
  output logic       step_strobe
);

  localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [3:0]    sw_s1;
  logic [3:0]    sw_sync;
  logic [3:0]    target;
  logic [TW-1:0] tmr;
  logic          tick;
  state_t        state;
  state_t        nxt;
  logic          step_up;
  logic          step_dn;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= SW;
      sw_sync <= sw_s1;
    end
  end

`ifdef PWM_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  // Candidate must survive DEBOUNCE_CYCLES equal samples before it is taken.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cand   <= '0;
      cnt    <= '0;
      target <= '0;
    end else if (sw_sync != cand) begin
      cand <= sw_sync;
      cnt  <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      target <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge sysclk) begin
    if (reset) target <= '0;
    else       target <= sw_sync;
  end
`endif

  // Tick is registered so a resumed ramp steps STEP_CYCLES+1 edges later.
  always_ff @(posedge sysclk) begin
    if (reset || !enable) begin
      tmr  <= '0;
      tick <= 1'b0;
    end else if (tmr == TW'(STEP_CYCLES - 1)) begin
      tmr  <= '0;
      tick <= 1'b1;
    end else begin
      tmr  <= tmr + 1'b1;
      tick <= 1'b0;
    end
  end

  always_comb begin
    nxt = HOLD;
    if (target > duty)      nxt = UP;
    else if (target < duty) nxt = DOWN;
  end

  assign step_up = tick && enable && (state == UP) && (duty != 4'hF);
  assign step_dn = tick && enable && (state == DOWN) && (duty != 4'h0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= HOLD;
      duty        <= '0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != HOLD);
      step_strobe <= step_up || step_dn;
      if (step_up)      duty <= duty + 1'b1;
      else if (step_dn) duty <= duty - 1'b1;
    end
  end

endmodule
